// File: rtl/div_unit.sv
// Multi-cycle signed divider (MIPS DIV): restoring division on magnitudes, one
// quotient bit per clock, then sign correction. Remainder on hiOut, quotient on loOut.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divStart,
  input  logic [WIDTH-1:0] divA,
  input  logic [WIDTH-1:0] divB,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut,
  output logic             divDone,
  output logic             divBusy,
  output logic             divZero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             quo_sign_q, quo_sign_d;
  logic             rem_sign_q, rem_sign_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    quo_sign_d = quo_sign_q;
    rem_sign_d = rem_sign_q;
    zero_d     = zero_q;

    mag_a = divA[WIDTH-1] ? -divA : divA;
    mag_b = divB[WIDTH-1] ? -divB : divB;
    // Shifted partial remainder with the next dividend bit, minus divisor, one bit wider
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (divStart) begin
          if (divB == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            quo_d      = mag_a;
            dvs_d      = mag_b;
            rem_d      = '0;
            cnt_d      = '0;
            quo_sign_d = divA[WIDTH-1] ^ divB[WIDTH-1];
            rem_sign_d = divA[WIDTH-1];
            zero_d     = 1'b0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = quo_sign_q ? -quo_q : quo_q;
        hi_d    = rem_sign_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      quo_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      quo_sign_q <= quo_sign_d;
      rem_sign_q <= rem_sign_d;
      zero_q     <= zero_d;
    end
  end

  assign hiOut   = hi_q;
  assign loOut   = lo_q;
  assign divZero = zero_q;
  assign divDone = (state_q == DONE);
  assign divBusy = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, done/busy timing, divide-by-zero,
// ignored restarts and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        divStart = 1'b0;
  logic [31:0] divA = '0;
  logic [31:0] divB = '0;
  logic [31:0] hiOut, loOut;
  logic        divDone, divBusy, divZero;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .divStart(divStart), .divA(divA), .divB(divB),
    .hiOut(hiOut), .loOut(loOut), .divDone(divDone), .divBusy(divBusy), .divZero(divZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind 0: plain op; 1: extra start 50/5 in cycle 10; 2: reset edge at end of cycle 15
  task automatic op(input logic [31:0] a, input logic [31:0] b, input int kind,
                    output int first_done, output int done_cnt, output int busy_cnt,
                    output logic zero_c1);
    first_done = 0; done_cnt = 0; busy_cnt = 0; zero_c1 = 1'bx;
    @(negedge clk);
    divA = a; divB = b; divStart = 1'b1;
    @(posedge clk); #1;
    divStart = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) zero_c1 = divZero;
      if (divDone) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (divBusy) busy_cnt++;
      divStart = 1'b0;
      if (kind == 1 && c == 10) begin
        divA = 32'd50; divB = 32'd5; divStart = 1'b1;
      end
      if (kind == 2 && c == 15) reset = 1'b0;
      if (kind == 2 && c == 16) begin
        check("rst_mid_busy", {31'b0, divBusy}, 32'd0);
        check("rst_mid_done", {31'b0, divDone}, 32'd0);
        check("rst_mid_hi", hiOut, 32'd0);
        check("rst_mid_lo", loOut, 32'd0);
        reset = 1'b1;
      end
    end
  endtask

  int fd, dc, bc;
  logic z1;

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", hiOut, 32'd0);
    check("rst_lo", loOut, 32'd0);
    check("rst_done", {31'b0, divDone}, 32'd0);
    check("rst_busy", {31'b0, divBusy}, 32'd0);
    check("rst_zero", {31'b0, divZero}, 32'd0);
    reset = 1'b1;

    op(32'd100, 32'd7, 0, fd, dc, bc, z1);
    check("p100_7_lo", loOut, 32'd14);
    check("p100_7_hi", hiOut, 32'd2);
    check("p100_7_zero", {31'b0, divZero}, 32'd0);
    check("p100_7_done_cycle", fd, 34);
    check("p100_7_done_cnt", dc, 1);
    check("p100_7_busy_cnt", bc, 34);

    op(32'hFFFF_FFF9, 32'd2, 0, fd, dc, bc, z1);
    check("m7_2_lo", loOut, 32'hFFFF_FFFD);
    check("m7_2_hi", hiOut, 32'hFFFF_FFFF);

    op(32'd7, 32'hFFFF_FFFE, 0, fd, dc, bc, z1);
    check("7_m2_lo", loOut, 32'hFFFF_FFFD);
    check("7_m2_hi", hiOut, 32'd1);

    op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, fd, dc, bc, z1);
    check("m100_m7_lo", loOut, 32'd14);
    check("m100_m7_hi", hiOut, 32'hFFFF_FFFE);

    op(32'd100, 32'd7, 0, fd, dc, bc, z1);
    op(32'd5, 32'd0, 0, fd, dc, bc, z1);
    check("dz_zero", {31'b0, divZero}, 32'd1);
    check("dz_done_cycle", fd, 1);
    check("dz_done_cnt", dc, 1);
    check("dz_busy_cnt", bc, 1);
    check("dz_hi_kept", hiOut, 32'd2);
    check("dz_lo_kept", loOut, 32'd14);

    op(32'd9, 32'd3, 0, fd, dc, bc, z1);
    check("9_3_zero_clr", {31'b0, z1}, 32'd0);
    check("9_3_lo", loOut, 32'd3);
    check("9_3_hi", hiOut, 32'd0);

    op(32'h8000_0000, 32'hFFFF_FFFF, 0, fd, dc, bc, z1);
    check("ovf_lo", loOut, 32'h8000_0000);
    check("ovf_hi", hiOut, 32'd0);
    check("ovf_zero", {31'b0, divZero}, 32'd0);

    op(32'd0, 32'd5, 0, fd, dc, bc, z1);
    check("0_5_lo", loOut, 32'd0);
    check("0_5_hi", hiOut, 32'd0);

    op(32'd100, 32'd7, 1, fd, dc, bc, z1);
    check("ign_lo", loOut, 32'd14);
    check("ign_hi", hiOut, 32'd2);
    check("ign_done_cycle", fd, 34);
    check("ign_done_cnt", dc, 1);

    op(32'd100, 32'd7, 2, fd, dc, bc, z1);
    check("rst_abort_done_cnt", dc, 0);

    op(32'd20, 32'd6, 0, fd, dc, bc, z1);
    check("20_6_lo", loOut, 32'd3);
    check("20_6_hi", hiOut, 32'd2);
    check("20_6_done_cycle", fd, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
